aes_word_loader: RTL and testbench
==================================

AES_WORD_LOADER -- requirements
Module: aes_word_loader

Interface
REQ-001 The block SHALL have parameter CIPHER_LAT, default 10, meaning clock cycles from cipher_data/cipher_key stable to cipher_result valid.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream word valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-006 The block SHALL have port in_data, input, 32 bits: input word.
REQ-007 The block SHALL have port in_is_key, input, 1 bit: 1 means key word, 0 means plaintext word.
REQ-008 The block SHALL have port cipher_data, output, 128 bits: plaintext block to the unrolled cipher.
REQ-009 The block SHALL have port cipher_key, output, 128 bits: key to the cipher.
REQ-010 The block SHALL have port cipher_result, input, 128 bits: ciphertext from the cipher.
REQ-011 The block SHALL have port out_valid, output, 1 bit: output word valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-013 The block SHALL have port out_data, output, 32 bits: ciphertext word.
REQ-014 The block SHALL have port out_last, output, 1 bit: fourth (final) word of a block.
REQ-015 The block SHALL have port busy, output, 1 bit: high in WAIT or DRAIN.

Function
REQ-016 The FSM SHALL have exactly three states, LOAD, WAIT and DRAIN, and SHALL enter LOAD at reset.
REQ-017 In LOAD, in_ready SHALL be 1; in WAIT and DRAIN, in_ready SHALL be 0.
REQ-018 A transfer SHALL occur only when in_valid and in_ready are both 1 on a clock edge.
REQ-019 Key words SHALL fill the key register most-significant word first (word 0 to [127:96], word 3 to [31:0]), indexed by a 2-bit key counter that wraps from 3 to 0.
REQ-020 Data words SHALL fill the data register in the same order, indexed by a 2-bit data counter.
REQ-021 When the 4th data word is accepted, the FSM SHALL go to WAIT, the data counter SHALL clear, and the latency counter SHALL load CIPHER_LAT.
REQ-022 Key words and data words MAY interleave freely in LOAD; the key used is the key register content at the LOAD-to-WAIT transition.
REQ-023 Key loading SHALL be optional per block: the key register persists until it is rewritten.
REQ-024 A partially written key SHALL be used as-is; the key counter position SHALL persist across blocks.
REQ-025 cipher_data and cipher_key SHALL be driven directly from their registers and SHALL remain unchanged throughout WAIT.
REQ-026 In WAIT, the latency counter SHALL decrement once per cycle.
REQ-027 When the latency counter is 1, the block SHALL capture cipher_result into the output register on that edge and SHALL enter DRAIN, for exactly CIPHER_LAT cycles in WAIT.
REQ-028 In DRAIN, out_valid SHALL be 1 and out_data SHALL be output register word k, with k = 0 to 3 taken most-significant word first.
REQ-029 k SHALL advance only when out_valid and out_ready are both 1; out_data SHALL be held stable while out_ready is 0.
REQ-030 out_last SHALL be 1 only when k = 3 in DRAIN.
REQ-031 When word 3 is accepted, the FSM SHALL return to LOAD and k SHALL clear; in_ready SHALL become 1 on the following cycle (no same-cycle bypass).
REQ-032 Outside DRAIN, out_valid and out_last SHALL be 0.
REQ-033 busy SHALL be 1 exactly when the state is WAIT or DRAIN.
REQ-034 Throughput SHALL be one block per (accepted input words + CIPHER_LAT + 4) cycles minimum; no overlap between blocks.

Reset
REQ-035 When rst_n is 0, asynchronously: state = LOAD; key, data and output registers = 0; all counters = 0.
REQ-036 Under reset, outputs SHALL be: in_ready = 1 after release (0 while asserted), out_valid = 0, out_last = 0, busy = 0, out_data = 0, cipher_data = 0, cipher_key = 0.
REQ-037 Reset mid-WAIT or mid-DRAIN SHALL discard the block with no partial output after release.

Structure
REQ-038 A shared package aes_pkg SHALL hold the FSM state enum, constant WORDS_PER_BLOCK = 4, and the default cipher latency.
REQ-039 No sub-module SHALL be used; the block is a single flat module instantiated beside the cipher, with cipher_data/cipher_key feeding its datain/key and its dataout feeding cipher_result.

Verification
REQ-040 The bench SHALL cover the FIPS-197 vector: key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then data 00112233, 44556677, 8899aabb, ccddeeff -> out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, with out_last on the 4th.
REQ-041 The bench SHALL cover a second block with no key words after REQ-040 -> same key used; busy high for exactly 10 cycles before out_valid.
REQ-042 The bench SHALL cover interleaved key/data words with random in_valid gaps -> ciphertext identical to the REQ-040 result.
REQ-043 The bench SHALL cover out_ready held 0 for 5 cycles at k = 2 -> out_data stable at d8cdb780, and in_ready stays 0.
REQ-044 The bench SHALL cover rst_n pulsed low during WAIT -> out_valid never asserts; cipher_key = 0; in_ready = 1 after release.
REQ-045 The bench SHALL cover in_valid held high during WAIT/DRAIN -> no words consumed; data counter unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES word loader: FSM states, block geometry, default cipher latency.
package aes_pkg;

    localparam int WORDS_PER_BLOCK    = 4;
    localparam int DEFAULT_CIPHER_LAT = 10;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Bit offset of 32-bit word idx in a 128-bit block, word 0 being the most significant.
    function automatic logic [6:0] word_lsb(input logic [1:0] idx);
        return {~idx, 5'b0_0000};
    endfunction

endpackage

// File: rtl/aes_word_loader.sv
// Packs 32-bit key/plaintext words into 128-bit blocks for an unrolled AES core and streams back
// the ciphertext as four words; latency is words in + CIPHER_LAT + 4, one block in flight at a time.
module aes_word_loader
    import aes_pkg::*;
#(
    parameter int CIPHER_LAT = DEFAULT_CIPHER_LAT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_is_key,
    output logic [127:0] cipher_data,
    output logic [127:0] cipher_key,
    input  logic [127:0] cipher_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int          LAT_W     = $clog2(CIPHER_LAT + 1);
    localparam logic [1:0]  LAST_WORD = 2'(WORDS_PER_BLOCK - 1);

    state_t             state;
    logic [1:0]         key_cnt;
    logic [1:0]         data_cnt;
    logic [1:0]         out_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [127:0]       key_reg;
    logic [127:0]       data_reg;
    logic [127:0]       out_reg;
    logic               in_fire;
    logic               out_fire;

    // Gated by rst_n so upstream never sees a ready while the block is held in reset.
    assign in_ready    = rst_n && (state == ST_LOAD);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;

    assign cipher_data = data_reg;
    assign cipher_key  = key_reg;
    assign out_data    = out_reg[word_lsb(out_cnt) +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            key_cnt   <= '0;
            data_cnt  <= '0;
            out_cnt   <= '0;
            lat_cnt   <= '0;
            key_reg   <= '0;
            data_reg  <= '0;
            out_reg   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (in_is_key) begin
                            key_reg[word_lsb(key_cnt) +: 32] <= in_data;
                            key_cnt <= key_cnt + 2'd1;
                        end else begin
                            data_reg[word_lsb(data_cnt) +: 32] <= in_data;
                            if (data_cnt == LAST_WORD) begin
                                data_cnt <= '0;
                                lat_cnt  <= LAT_W'(CIPHER_LAT);
                                busy     <= 1'b1;
                                state    <= ST_WAIT;
                            end else begin
                                data_cnt <= data_cnt + 2'd1;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    // Count of 1 marks the edge on which the cipher output has settled.
                    if (lat_cnt == LAT_W'(1)) begin
                        out_reg   <= cipher_result;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        if (out_cnt == LAST_WORD) begin
                            out_cnt   <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= ST_LOAD;
                        end else begin
                            out_cnt  <= out_cnt + 2'd1;
                            out_last <= ((out_cnt + 2'd1) == LAST_WORD);
                        end
                    end
                end
                default: begin
                    state     <= ST_LOAD;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_word_loader.sv
// Bench for aes_word_loader: a delayed stand-in cipher plus a word-level model of key/data packing.
module tb_aes_word_loader;
    import aes_pkg::*;

    localparam int LAT = DEFAULT_CIPHER_LAT;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_is_key;
    logic [127:0] cipher_data;
    logic [127:0] cipher_key;
    logic [127:0] cipher_result;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aes_word_loader #(.CIPHER_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_is_key(in_is_key),
        .cipher_data(cipher_data), .cipher_key(cipher_key), .cipher_result(cipher_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    // Stand-in cipher: real AES answer for the FIPS-197 vector, a keyed scramble otherwise.
    function automatic logic [127:0] cipher_fn(input logic [127:0] d, input logic [127:0] k);
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return d ^ {k[63:0], k[127:64]} ^ {d[95:0], d[127:96]} ^ 128'h3c5a_96e1_0f1e_2d4b_8778_a5c3_d2e1_f00f;
    endfunction

    // Result is valid LAT cycles after its inputs settle; earlier it still reflects stale inputs.
    logic [127:0] pipe [0:LAT-2];
    always @(posedge clk) begin
        pipe[0] <= cipher_fn(cipher_data, cipher_key);
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign cipher_result = pipe[LAT-2];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: words land in a 4-entry array at a wrapping position.
    logic [31:0]  m_key [4];
    logic [31:0]  m_data[4];
    int           m_kp;
    int           m_dp;
    logic [127:0] m_ct;

    logic [31:0]  wd[$];
    bit           wk[$];

    function automatic logic [127:0] pack4(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] w2, input logic [31:0] w3);
        return {w0, w1, w2, w3};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_key[i]  = '0;
            m_data[i] = '0;
        end
        m_kp = 0;
        m_dp = 0;
    endtask

    task automatic send_words(input int max_gap);
        for (int i = 0; i < wd.size(); i++) begin
            int gap;
            gap = $urandom_range(max_gap, 0);
            repeat (gap) begin
                in_valid  = 1'b0;
                in_data   = $urandom;
                in_is_key = 1'($urandom);
                @(negedge clk);
                check("in_ready_idle", in_ready, 1);
            end
            check("in_ready_load", in_ready, 1);
            in_valid  = 1'b1;
            in_data   = wd[i];
            in_is_key = wk[i];
            @(negedge clk);
            if (wk[i]) begin
                m_key[m_kp] = wd[i];
                m_kp = (m_kp + 1) % 4;
            end else begin
                m_data[m_dp] = wd[i];
                m_dp = (m_dp + 1) % 4;
                if (m_dp == 0)
                    m_ct = cipher_fn(pack4(m_data[0], m_data[1], m_data[2], m_data[3]),
                                     pack4(m_key[0], m_key[1], m_key[2], m_key[3]));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle_inputs(input bit hold_valid);
        in_valid  = hold_valid;
        in_data   = $urandom;
        in_is_key = 1'($urandom);
    endtask

    // Called right after the 4th data word's edge; covers the wait and all four output words.
    task automatic finish_block(input logic [127:0] exp, input int stall_k, input int stall_n,
                                input bit rnd_stall, input bit hold_valid);
        int  cnt;
        logic [127:0] exp_key;
        logic [127:0] exp_dat;
        exp_key = pack4(m_key[0], m_key[1], m_key[2], m_key[3]);
        exp_dat = pack4(m_data[0], m_data[1], m_data[2], m_data[3]);
        out_ready = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < LAT + 5) begin
            idle_inputs(hold_valid);
            if (busy) cnt++;
            check("wait_in_ready", in_ready, 0);
            check("wait_out_last", out_last, 0);
            check("wait_cipher_key", cipher_key, exp_key);
            check("wait_cipher_data", cipher_data, exp_dat);
            @(negedge clk);
        end
        check("wait_cycles", cnt, LAT);
        for (int k = 0; k < 4; k++) begin
            int n;
            logic [31:0] w;
            w = 32'(exp >> (96 - 32 * k));
            n = (k == stall_k) ? stall_n : (rnd_stall ? int'($urandom_range(2, 0)) : 0);
            idle_inputs(hold_valid);
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, w);
            check("drain_last", out_last, (k == 3));
            check("drain_busy", busy, 1);
            check("drain_in_ready", in_ready, 0);
            repeat (n) begin
                @(negedge clk);
                idle_inputs(hold_valid);
                check("stall_data", out_data, w);
                check("stall_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_out_valid", out_valid, 0);
        check("post_out_last", out_last, 0);
    endtask

    task automatic build_random_block();
        int nk;
        int nd;
        wd.delete();
        wk.delete();
        nk = $urandom_range(5, 0);
        nd = 4;
        while (nk + nd > 0) begin
            bit is_key;
            if (nk == 0)                 is_key = 1'b0;
            else if (nd == 1)            is_key = 1'b1;
            else                         is_key = 1'($urandom);
            wk.push_back(is_key);
            wd.push_back($urandom);
            if (is_key) nk--; else nd--;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_is_key = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_cipher_data", cipher_data, 0);
        check("rst_cipher_key", cipher_key, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);

        // FIPS-197 vector, key words then data words
        wd = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
               32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        wk = '{1, 1, 1, 1, 0, 0, 0, 0};
        send_words(0);
        finish_block(FIPS_CT, -1, 0, 0, 0);

        // Same plaintext, no key words; long stall on word 2 with in_valid held high
        wd = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        wk = '{0, 0, 0, 0};
        send_words(0);
        finish_block(FIPS_CT, 2, 5, 0, 1);

        // Interleaved key/data words with random gaps
        wd = '{32'h00010203, 32'h00112233, 32'h04050607, 32'h08090a0b,
               32'h44556677, 32'h8899aabb, 32'h0c0d0e0f, 32'hccddeeff};
        wk = '{1, 0, 1, 1, 0, 0, 1, 0};
        send_words(3);
        finish_block(FIPS_CT, -1, 0, 1, 0);

        // Reset pulse during WAIT discards the block
        build_random_block();
        send_words(1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cipher_key", cipher_key, 0);
        check("mid_rst_cipher_data", cipher_data, 0);
        check("mid_rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_in_ready", in_ready, 1);
        check("mid_rel_cipher_key", cipher_key, 0);
        begin
            int seen;
            seen = 0;
            repeat (LAT + 6) begin
                if (out_valid || busy) seen++;
                @(negedge clk);
            end
            check("mid_rel_no_output", seen, 0);
        end

        // Randomised blocks: optional/partial keys, gaps, stalls, held in_valid
        for (int b = 0; b < 20; b++) begin
            build_random_block();
            send_words(2);
            finish_block(m_ct, int'($urandom_range(4, 0)), int'($urandom_range(4, 1)), 1, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
